data_bus_arbiter: RTL and testbench

Two-port arbiter and transaction sequencer in front of `DataBusControl`. It shares the single data-bus port between requester C (core load/store path) and requester A (auxiliary master: program loader / debug). Each request runs as a multi-cycle transaction (issue, wait for `ready`, complete). A timeout guards against a device that never answers.

---
 rtl/riscuin_bus_pkg.sv | 14 +
 rtl/bus_timeout_counter.sv | 18 +
 rtl/data_bus_arbiter.sv | 100 ++++++++++
 tb/tb_data_bus_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/riscuin_bus_pkg.sv
// riscuin_bus_pkg: shared bus types, size/owner encodings and helpers
package riscuin_bus_pkg;
  localparam int MEM_DATA_ADDR_WIDTH = 32;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} bus_state_t;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic OWN_C = 1'b0;
  localparam logic OWN_A = 1'b1;
  // The reserved size code 11 travels on the bus as a plain word transfer.
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == 2'b11) ? SIZE_WORD : s;
  endfunction
endpackage

// File: rtl/bus_timeout_counter.sv
// bus_timeout_counter: counts WAIT cycles and flags the last permitted one
module bus_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
  assign expired = (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: round-robin two-port arbiter and transaction sequencer for the data bus
module data_bus_arbiter
  import riscuin_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_DATA_ADDR_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [1:0]            c_size,
  input  logic                  c_unsigned,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_gnt,
  output logic                  c_done,
  output logic                  c_err,
  output logic [DATA_WIDTH-1:0] c_rdata,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [1:0]            a_size,
  input  logic                  a_unsigned,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_done,
  output logic                  a_err,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  bus_wd,
  output logic                  bus_rd,
  output logic [1:0]            bus_size,
  output logic                  bus_unsigned,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ready
);
  bus_state_t state, nxt;
  logic owner, last, we_q, err_q, expired, accept, wait_end, nxt_own;
  logic [DATA_WIDTH-1:0] rd_val;
  assign accept   = (state == ST_IDLE) && (c_req || a_req);
  assign wait_end = (state == ST_WAIT) && (bus_ready || expired);
  // On a tie the requester not served last wins; a lone requester always wins.
  assign nxt_own  = (c_req && a_req) ? ~last : (c_req ? OWN_C : OWN_A);
  assign rd_val   = bus_ready ? bus_rdata : '0;
  always_comb
    nxt = (state == ST_IDLE)  ? (accept ? ST_ISSUE : ST_IDLE) :
          (state == ST_ISSUE) ? ST_WAIT :
          (state == ST_WAIT)  ? (wait_end ? ST_DONE : ST_WAIT) : ST_IDLE;
  bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == ST_ISSUE),
    .en      ((state == ST_WAIT) && !bus_ready),
    .expired (expired)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= ST_IDLE;
      owner        <= OWN_C;
      last         <= OWN_A;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      bus_size     <= '0;
      bus_unsigned <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        owner        <= nxt_own;
        we_q         <= (nxt_own == OWN_C) ? c_we : a_we;
        bus_size     <= norm_size((nxt_own == OWN_C) ? c_size : a_size);
        bus_unsigned <= (nxt_own == OWN_C) ? c_unsigned : a_unsigned;
        bus_addr     <= (nxt_own == OWN_C) ? c_addr : a_addr;
        bus_wdata    <= (nxt_own == OWN_C) ? c_wdata : a_wdata;
      end
      if (wait_end) err_q <= !bus_ready;
      if (state == ST_DONE) last <= owner;
    end
  // Reads load data (or zero on timeout); writes leave the port's last read data alone.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      c_rdata <= '0;
      a_rdata <= '0;
    end else if (wait_end && !we_q) begin
      if (owner == OWN_C) c_rdata <= rd_val;
      else a_rdata <= rd_val;
    end
  assign c_gnt  = (state != ST_IDLE) && (owner == OWN_C);
  assign a_gnt  = (state != ST_IDLE) && (owner == OWN_A);
  assign c_done = (state == ST_DONE) && (owner == OWN_C);
  assign a_done = (state == ST_DONE) && (owner == OWN_A);
  assign c_err  = c_done && err_q;
  assign a_err  = a_done && err_q;
  assign bus_wd = (state == ST_ISSUE) && we_q;
  assign bus_rd = (state == ST_ISSUE) && !we_q;
endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter: directed stimulus with a transaction-level reference model
module tb_data_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic c_req = 0, c_we = 0, c_unsigned = 0, a_req = 0, a_we = 0, a_unsigned = 0;
  logic [1:0] c_size = 0, a_size = 0;
  logic [AW-1:0] c_addr = 0, a_addr = 0;
  logic [DW-1:0] c_wdata = 0, a_wdata = 0, bus_rdata = 0;
  logic bus_ready = 0;
  logic c_gnt, c_done, c_err, a_gnt, a_done, a_err, bus_wd, bus_rd, bus_unsigned;
  logic [DW-1:0] c_rdata, a_rdata, bus_wdata;
  logic [AW-1:0] bus_addr;
  logic [1:0] bus_size;
  data_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_unsigned(c_unsigned),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_gnt(c_gnt), .c_done(c_done),
    .c_err(c_err), .c_rdata(c_rdata),
    .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_unsigned(a_unsigned),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt), .a_done(a_done),
    .a_err(a_err), .a_rdata(a_rdata),
    .bus_wd(bus_wd), .bus_rd(bus_rd), .bus_size(bus_size), .bus_unsigned(bus_unsigned),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  // Reference model: t counts cycles since acceptance (1 = issue cycle), dt is the
  // cycle index of the completion pulse once known.
  bit m_busy = 0, m_own = 0, m_last = 1, m_we = 0, m_uns = 0, m_err = 0;
  int m_t = 0, m_dt = 0;
  logic [1:0] m_size = 0;
  logic [AW-1:0] m_addr = 0;
  logic [DW-1:0] m_wdata = 0;
  logic [DW-1:0] m_rd [2] = '{0, 0};
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_busy = 0; m_own = 0; m_last = 1; m_we = 0; m_uns = 0; m_err = 0;
      m_t = 0; m_dt = 0; m_size = 0; m_addr = 0; m_wdata = 0; m_rd[0] = 0; m_rd[1] = 0;
    end else if (!m_busy) begin
      if (c_req || a_req) begin
        m_own   = (c_req && a_req) ? !m_last : !c_req;
        m_we    = m_own ? a_we : c_we;
        m_size  = m_own ? a_size : c_size;
        if (m_size == 2'd3) m_size = 2'd2;
        m_uns   = m_own ? a_unsigned : c_unsigned;
        m_addr  = m_own ? a_addr : c_addr;
        m_wdata = m_own ? a_wdata : c_wdata;
        m_busy = 1; m_t = 1; m_dt = 0;
      end
    end else if (m_dt != 0 && m_t == m_dt) begin
      m_last = m_own;
      m_busy = 0;
    end else begin
      if (m_t >= 2 && m_dt == 0) begin
        if (bus_ready) begin
          m_dt = m_t + 1; m_err = 0;
          if (!m_we) m_rd[m_own] = bus_rdata;
        end else if (m_t - 2 == TO - 1) begin
          m_dt = m_t + 1; m_err = 1;
          if (!m_we) m_rd[m_own] = '0;
        end
      end
      m_t++;
    end
  end
  always @(negedge clk) begin
    logic e_done;
    e_done = m_busy && m_dt != 0 && m_dt == m_t;
    chk("c_gnt", c_gnt, m_busy && !m_own);
    chk("a_gnt", a_gnt, m_busy && m_own);
    chk("c_done", c_done, e_done && !m_own);
    chk("a_done", a_done, e_done && m_own);
    chk("c_err", c_err, e_done && !m_own && m_err);
    chk("a_err", a_err, e_done && m_own && m_err);
    chk("c_rdata", c_rdata, m_rd[0]);
    chk("a_rdata", a_rdata, m_rd[1]);
    chk("bus_wd", bus_wd, m_busy && m_t == 1 && m_we);
    chk("bus_rd", bus_rd, m_busy && m_t == 1 && !m_we);
    chk("bus_addr", bus_addr, m_addr);
    chk("bus_wdata", bus_wdata, m_wdata);
    chk("bus_size", bus_size, m_size);
    chk("bus_unsigned", bus_unsigned, m_uns);
  end
  bit c_hold = 0, a_hold = 0;
  // One clock cycle; a requester drops req on the edge that samples its done.
  task automatic step();
    logic cd, ad;
    @(negedge clk);
    cd = c_done; ad = a_done;
    @(posedge clk);
    #1;
    if (cd && !c_hold) c_req = 0;
    if (ad && !a_hold) a_req = 0;
  endtask
  initial begin
    int own_q [4];
    int cyc_q [4];
    int n, n_rd;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {c_gnt, a_gnt, c_done, a_done, bus_wd, bus_rd}, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_rdata", c_rdata, 0);
    rst = 1;
    step();
    // C word read answered on the first WAIT cycle
    c_req = 1; c_we = 0; c_size = 2'b10; c_addr = 'h010;
    bus_rdata = 32'hDEADBEEF; bus_ready = 1;
    step(); chk("t1_bus_rd", bus_rd, 1); chk("t1_addr", bus_addr, 'h010);
    step(); chk("t1_rd_once", bus_rd, 0); chk("t1_early_done", c_done, 0);
    step();
    chk("t1_c_done", c_done, 1); chk("t1_c_rdata", c_rdata, 32'hDEADBEEF);
    chk("t1_c_err", c_err, 0); chk("t1_a_quiet", {a_gnt, a_done, a_err}, 0);
    chk("t1_a_rdata", a_rdata, 0);
    step(); chk("t1_done_pulse", c_done, 0);
    bus_ready = 0;
    rst = 0; step(); rst = 1;
    // simultaneous C write and A read straight after reset
    c_req = 1; c_we = 1; c_size = 2'b00; c_addr = 'h020; c_wdata = 32'h11223344;
    a_req = 1; a_we = 0; a_size = 2'b01; a_unsigned = 1; a_addr = 'h040;
    bus_rdata = 32'h0000CAFE; bus_ready = 1;
    step();
    chk("t2_bus_wd", bus_wd, 1); chk("t2_addr", bus_addr, 'h020);
    chk("t2_wdata", bus_wdata, 32'h11223344); chk("t2_gnt", {c_gnt, a_gnt}, 2'b10);
    step(); step();
    chk("t2_c_done", c_done, 1); chk("t2_wr_keeps_rdata", c_rdata, 0);
    step(); chk("t2_idle", a_gnt, 0);
    step();
    chk("t2_a_rd", bus_rd, 1); chk("t2_a_addr", bus_addr, 'h040);
    chk("t2_a_size", bus_size, 2'b01); chk("t2_a_uns", bus_unsigned, 1);
    step(); step();
    chk("t2_a_done", a_done, 1); chk("t2_a_rdata", a_rdata, 32'h0000CAFE);
    step();
    // both hold req: strict alternation, one completion every 4 cycles
    c_hold = 1; a_hold = 1; n = 0;
    c_req = 1; c_we = 0; c_unsigned = 0; c_addr = 'h100;
    a_req = 1; a_we = 1; a_unsigned = 0; a_addr = 'h200; a_wdata = 32'h0A0B0C0D;
    bus_rdata = 32'h00C0FFEE;
    for (int i = 1; i <= 15; i++) begin
      step();
      if ((c_done || a_done) && n < 4) begin
        own_q[n] = a_done ? 1 : 0; cyc_q[n] = i; n++;
      end
    end
    c_req = 0; a_req = 0; c_hold = 0; a_hold = 0;
    chk("t3_count", n, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t3_owner", own_q[k], k % 2);
      chk("t3_cycle", cyc_q[k], 3 + 4 * k);
    end
    step();
    bus_ready = 0;
    // A read timing out
    a_req = 1; a_we = 0; a_size = 2'b10; a_addr = 'h300; bus_rdata = 32'h12345678;
    n_rd = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (bus_rd) n_rd++;
      if (i == 5) chk("t4_not_yet", a_done, 0);
    end
    chk("t4_a_done", a_done, 1); chk("t4_a_err", a_err, 1);
    chk("t4_a_rdata", a_rdata, 0); chk("t4_rd_pulses", n_rd, 1);
    step();
    // ready arrives on the last permitted WAIT cycle
    c_req = 1; c_we = 0; c_addr = 'h400; bus_rdata = 32'h55AA1234;
    repeat (5) step();
    chk("t5_not_yet", c_done, 0);
    bus_ready = 1;
    step();
    chk("t5_c_done", c_done, 1); chk("t5_c_err", c_err, 0);
    chk("t5_c_rdata", c_rdata, 32'h55AA1234);
    bus_ready = 0;
    step();
    // asynchronous reset during WAIT of a C write
    c_req = 1; c_we = 1; c_addr = 'h080; c_wdata = 32'hA5A5A5A5;
    step(); step();
    #2 rst = 0;
    #1;
    chk("t6_ctrl", {c_gnt, a_gnt, c_done, a_done, c_err, a_err, bus_wd, bus_rd, bus_unsigned}, 0);
    chk("t6_addr", bus_addr, 0); chk("t6_wdata", bus_wdata, 0);
    chk("t6_size", bus_size, 0); chk("t6_rdata", {c_rdata, a_rdata}, 0);
    c_req = 0;
    step(); step();
    rst = 1;
    step(); step();
    c_req = 1; c_we = 0; c_addr = 'h010; bus_rdata = 32'h0BADF00D; bus_ready = 1;
    step(); step(); step();
    chk("t6_new_done", c_done, 1); chk("t6_new_rdata", c_rdata, 32'h0BADF00D);
    step();
    bus_ready = 0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
